bus_arbiter_param: RTL and testbench



---
 rtl/bus_pkg.sv | 14 +
 rtl/arb_pick.sv | 31 +++
 rtl/bus_arbiter_param.sv | 110 +++++++++++
 tb/tb_bus_arbiter_param.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: shared state codes and default widths for the serial bus controller.
package bus_pkg;
  localparam int STATE_W = 3;
  localparam int DATA_WIDTH = 8;
  localparam int ADDRS_WIDTH = 15;
  localparam int MID_W = 4;
  localparam int SID_W = 3;
  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    GRANT   = 3'd1,
    BUSY    = 3'd2,
    RELEASE = 3'd3
  } state_e;
endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational picker; lowest set index, or first set index at/above ptr_i
// (wrapping) when mode_i is high.
module arb_pick #(
  parameter int N = 12,
  parameter int W = 4
) (
  input  logic [N-1:0] reqs_i,
  input  logic [W-1:0] ptr_i,
  input  logic         mode_i,
  output logic         valid_o,
  output logic [W-1:0] idx_o
);
  logic [W-1:0] sh;
  logic [2*N-1:0] dbl;
  int j;
  // rotate so bit 0 is the pointer position, then take the lowest set bit
  always_comb begin
    sh = mode_i ? ptr_i : '0;
    dbl = {reqs_i, reqs_i} >> sh;
    valid_o = 1'b0;
    idx_o = '0;
    j = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (dbl[i]) begin
        j = i + int'(sh);
        valid_o = 1'b1;
        idx_o = W'(j >= N ? j - N : j);
      end
    end
  end
endmodule

// File: rtl/bus_arbiter_param.sv
// bus_arbiter_param: shared-bus arbiter with grant timeout, slave tracking and
// optional utilisation counter (enabled by defining ARB_STATS_EN).
module bus_arbiter_param
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = 12,
  parameter int NUM_SLAVES  = 6,
  parameter int MID_WIDTH   = MID_W,
  parameter int SID_WIDTH   = SID_W,
  parameter int TIMEOUT_LEN = 6,
  parameter int ARB_MODE    = 0
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] m_reqs,
  output logic [NUM_MASTERS-1:0] m_grants,
  input  logic [NUM_SLAVES-1:0]  slaves,
  input  logic                   bus_util,
  output logic [STATE_W-1:0]     state,
  output logic [MID_WIDTH-1:0]   mid_current,
  output logic [SID_WIDTH-1:0]   sid_current,
  output logic                   timeout_pulse,
  output logic                   slave_conflict,
  output logic [15:0]            util_cycles
);
  localparam logic [TIMEOUT_LEN-1:0] CNT_LAST = TIMEOUT_LEN'((1 << TIMEOUT_LEN) - 2);
  state_e state_q;
  logic [NUM_MASTERS-1:0] grants_q;
  logic [MID_WIDTH-1:0] mid_q, rr_q, m_idx;
  logic [SID_WIDTH-1:0] sid_q, s_idx;
  logic [TIMEOUT_LEN-1:0] cnt_q;
  logic to_q, conf_q, m_valid, s_valid, multi;

  arb_pick #(.N(NUM_MASTERS), .W(MID_WIDTH)) u_mpick (
    .reqs_i(m_reqs), .ptr_i(rr_q), .mode_i(ARB_MODE != 0), .valid_o(m_valid), .idx_o(m_idx)
  );
  arb_pick #(.N(NUM_SLAVES), .W(SID_WIDTH)) u_spick (
    .reqs_i(slaves), .ptr_i({SID_WIDTH{1'b0}}), .mode_i(1'b0), .valid_o(s_valid), .idx_o(s_idx)
  );

  assign multi = (slaves & (slaves - 1'b1)) != '0;

  // a GRANT cycle at CNT_LAST is the final one, so GRANT lasts 2^TIMEOUT_LEN-1 cycles
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      grants_q <= '0;
      mid_q    <= '0;
      rr_q     <= '0;
      sid_q    <= '0;
      cnt_q    <= '0;
      to_q     <= 1'b0;
      conf_q   <= 1'b0;
    end else begin
      to_q <= 1'b0;
      case (state_q)
        IDLE: if (m_valid) begin
          grants_q <= NUM_MASTERS'(1) << m_idx;
          mid_q    <= m_idx;
          cnt_q    <= '0;
          state_q  <= GRANT;
        end
        GRANT: if (bus_util) begin
          state_q <= BUSY;
          cnt_q   <= '0;
        end else if (!m_reqs[mid_q] || cnt_q == CNT_LAST) begin
          state_q  <= RELEASE;
          grants_q <= '0;
          to_q     <= m_reqs[mid_q];
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        BUSY: begin
          if (s_valid) sid_q <= s_idx;
          if (multi) conf_q <= 1'b1;
          if (!bus_util) begin
            state_q  <= RELEASE;
            grants_q <= '0;
          end
        end
        RELEASE: begin
          rr_q    <= (mid_q == MID_WIDTH'(NUM_MASTERS - 1)) ? '0 : mid_q + 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q  <= IDLE;
          grants_q <= '0;
        end
      endcase
    end
  end

  assign m_grants       = grants_q;
  assign state          = state_q;
  assign mid_current    = mid_q;
  assign sid_current    = sid_q;
  assign timeout_pulse  = to_q;
  assign slave_conflict = conf_q;

`ifdef ARB_STATS_EN
  logic [15:0] util_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) util_q <= '0;
    else if (bus_util && util_q != 16'hFFFF) util_q <= util_q + 1'b1;
  end
  assign util_cycles = util_q;
`else
  assign util_cycles = 16'd0;
`endif
endmodule

// File: tb/tb_bus_arbiter_param.sv
// tb_bus_arbiter_param: randomized and directed checks of fixed-priority and
// round-robin instances sharing one set of bus inputs.
module tb_bus_arbiter_param;
  localparam int NM = 12;
  localparam int NS = 6;
  localparam int TL = 6;
  logic clk, rstn, bus_util;
  logic [NM-1:0] m_reqs, g0, g1;
  logic [NS-1:0] slaves;
  logic [2:0] st0, st1, sid0, sid1;
  logic [3:0] mid0, mid1;
  logic to0, to1, cf0, cf1;
  logic [15:0] uc0, uc1;
  int checks = 0;
  int passes = 0;
  int rr_m = 0;
  int sid_m = 0;
  int util_m = 0;
  bit conf_m = 0;

  bus_arbiter_param #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .MID_WIDTH(4), .SID_WIDTH(3),
                      .TIMEOUT_LEN(TL), .ARB_MODE(0)) u_fp (
    .clk(clk), .rstn(rstn), .m_reqs(m_reqs), .m_grants(g0), .slaves(slaves), .bus_util(bus_util),
    .state(st0), .mid_current(mid0), .sid_current(sid0), .timeout_pulse(to0),
    .slave_conflict(cf0), .util_cycles(uc0));
  bus_arbiter_param #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .MID_WIDTH(4), .SID_WIDTH(3),
                      .TIMEOUT_LEN(TL), .ARB_MODE(1)) u_rr (
    .clk(clk), .rstn(rstn), .m_reqs(m_reqs), .m_grants(g1), .slaves(slaves), .bus_util(bus_util),
    .state(st1), .mid_current(mid1), .sid_current(sid1), .timeout_pulse(to1),
    .slave_conflict(cf1), .util_cycles(uc1));

  always #5 clk = ~clk;

  function automatic int lowest(input logic [NM-1:0] v);
    for (int i = 0; i < NM; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic int rr_win(input logic [NM-1:0] v, input int p);
    for (int o = 0; o < NM; o++) if (v[(p + o) % NM]) return (p + o) % NM;
    return 0;
  endfunction

  function automatic logic [15:0] exp_util();
`ifdef ARB_STATS_EN
    return 16'(util_m);
`else
    return 16'd0;
`endif
  endfunction

  // kind: 0 = transfer of len util cycles, 1 = grant timeout, 2 = request dropped in GRANT
  task automatic txn(input logic [NM-1:0] r, input int len, input logic [NS-1:0] s, input int kind);
    int w0, w1, n;
    logic [NM-1:0] e0, e1;
    w0 = lowest(r);
    w1 = rr_win(r, rr_m);
    e0 = NM'(1) << w0;
    e1 = NM'(1) << w1;
    m_reqs = r;
    @(negedge clk);
    checks++;
    if ({st0, g0, mid0, st1, g1, mid1} !== {3'd1, e0, 4'(w0), 3'd1, e1, 4'(w1)})
      $display("FAIL grant r=%h: got st=%0d/%0d g=%h/%h mid=%0d/%0d want st=1 g=%h/%h mid=%0d/%0d",
               r, st0, st1, g0, g1, mid0, mid1, e0, e1, w0, w1);
    else passes++;
    if (kind == 1) begin
      n = 0;
      while (st0 == 3'd1 && n < 200) begin
        n++;
        @(negedge clk);
      end
      checks++;
      if (n != (1 << TL) - 1) $display("FAIL timeout_len: got %0d grant cycles want %0d", n, (1 << TL) - 1);
      else passes++;
      checks++;
      if ({st0, st1, g0, g1, to0, to1} !== {3'd3, 3'd3, 24'd0, 2'b11})
        $display("FAIL timeout_release: got st=%0d/%0d g=%h/%h pulse=%b/%b want st=3 g=0 pulse=1",
                 st0, st1, g0, g1, to0, to1);
      else passes++;
      m_reqs = '0;
    end else if (kind == 2) begin
      m_reqs = '0;
      @(negedge clk);
      checks++;
      if ({st0, st1, g0, g1, to0, to1} !== {3'd3, 3'd3, 24'd0, 2'b00})
        $display("FAIL drop_release: got st=%0d/%0d g=%h/%h pulse=%b/%b want st=3 g=0 pulse=0",
                 st0, st1, g0, g1, to0, to1);
      else passes++;
    end else begin
      bus_util = 1'b1;
      slaves = s;
      repeat (len) @(negedge clk);
      checks++;
      if ({st0, st1, g0, g1} !== {3'd2, 3'd2, e0, e1})
        $display("FAIL busy_hold: got st=%0d/%0d g=%h/%h want st=2 g=%h/%h", st0, st1, g0, g1, e0, e1);
      else passes++;
      bus_util = 1'b0;
      m_reqs = '0;
      if (s != '0) sid_m = lowest(NM'(s));
      if ($countones(s) > 1) conf_m = 1;
      util_m = (util_m + len > 65535) ? 65535 : util_m + len;
      @(negedge clk);
      checks++;
      if ({st0, st1, g0, g1, to0, to1} !== {3'd3, 3'd3, 24'd0, 2'b00})
        $display("FAIL busy_release: got st=%0d/%0d g=%h/%h pulse=%b/%b want st=3 g=0 pulse=0",
                 st0, st1, g0, g1, to0, to1);
      else passes++;
      checks++;
      if ({sid0, sid1, cf0, cf1} !== {3'(sid_m), 3'(sid_m), conf_m, conf_m})
        $display("FAIL slave_track s=%b: got sid=%0d/%0d conflict=%b/%b want sid=%0d conflict=%b",
                 s, sid0, sid1, cf0, cf1, sid_m, conf_m);
      else passes++;
      checks++;
      if ({uc0, uc1} !== {exp_util(), exp_util()})
        $display("FAIL util_cycles: got %0d/%0d want %0d", uc0, uc1, exp_util());
      else passes++;
    end
    rr_m = (w1 + 1) % NM;
    @(negedge clk);
    checks++;
    if ({st0, st1, g0, g1, to0, to1, mid0, mid1} !== {3'd0, 3'd0, 24'd0, 2'b00, 4'(w0), 4'(w1)})
      $display("FAIL back_idle: got st=%0d/%0d g=%h/%h pulse=%b/%b mid=%0d/%0d want st=0 g=0 pulse=0 mid=%0d/%0d",
               st0, st1, g0, g1, to0, to1, mid0, mid1, w0, w1);
    else passes++;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({g0, g1, st0, st1, mid0, mid1, sid0, sid1, to0, to1, cf0, cf1, uc0, uc1} !== '0)
      $display("FAIL reset: got g=%h/%h st=%0d/%0d mid=%0d/%0d sid=%0d/%0d to=%b/%b cf=%b/%b uc=%0d/%0d want all 0",
               g0, g1, st0, st1, mid0, mid1, sid0, sid1, to0, to1, cf0, cf1, uc0, uc1);
    else passes++;
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if ({st0, st1, g0, g1} !== '0) $display("FAIL idle_noreq: got st=%0d/%0d g=%h/%h want 0", st0, st1, g0, g1);
    else passes++;
  endtask

  task automatic test_fixed_priority();
    txn(12'h014, 4, 6'b001000, 0);
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 4; i++) txn(12'h014, 2, 6'b000000, 0);
    txn(12'h801, 2, 6'b000000, 0);
    txn(12'h801, 2, 6'b000000, 0);
  endtask

  task automatic test_timeout();
    txn(12'h004, 0, 6'b0, 1);
  endtask

  task automatic test_transfer();
    txn(12'h004, 40, 6'b001000, 0);
    txn(12'h0A0, 0, 6'b0, 2);
  endtask

  task automatic test_back_to_back();
    int w1a, w1b;
    logic [NM-1:0] e1;
    slaves = '0;
    m_reqs = 12'h014;
    w1a = rr_win(12'h014, rr_m);
    @(negedge clk);
    bus_util = 1'b1;
    repeat (2) @(negedge clk);
    bus_util = 1'b0;
    util_m += 2;
    rr_m = (w1a + 1) % NM;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({st0, st1, g0, g1} !== '0) $display("FAIL gap_idle: got st=%0d/%0d g=%h/%h want 0", st0, st1, g0, g1);
    else passes++;
    @(negedge clk);
    w1b = rr_win(12'h014, rr_m);
    e1 = NM'(1) << w1b;
    checks++;
    if ({st0, st1, g0, g1} !== {3'd1, 3'd1, 12'h004, e1} || w1b == w1a)
      $display("FAIL pending_regrant: got st=%0d/%0d g=%h/%h want st=1 g=004/%h", st0, st1, g0, g1, e1);
    else passes++;
    m_reqs = '0;
    rr_m = (w1b + 1) % NM;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_conflict();
    txn(12'h004, 5, 6'b011000, 0);
    txn(12'h300, 3, 6'b000001, 0);
  endtask

  task automatic test_reset_mid();
    m_reqs = 12'h004;
    @(negedge clk);
    bus_util = 1'b1;
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({g0, g1, st0, st1, cf0, cf1, uc0, uc1, mid0, mid1} !== '0)
      $display("FAIL async_reset: got g=%h/%h st=%0d/%0d cf=%b/%b uc=%0d/%0d mid=%0d/%0d want 0",
               g0, g1, st0, st1, cf0, cf1, uc0, uc1, mid0, mid1);
    else passes++;
    rr_m = 0; sid_m = 0; conf_m = 0; util_m = 0;
    bus_util = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if ({st0, st1, g0, g1} !== {3'd1, 3'd1, 12'h004, 12'h004})
      $display("FAIL post_reset_grant: got st=%0d/%0d g=%h/%h want st=1 g=004", st0, st1, g0, g1);
    else passes++;
    m_reqs = '0;
    rr_m = 3;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++)
      txn(NM'($urandom_range(1, 4095)), $urandom_range(2, 12), NS'($urandom_range(0, 63)),
          ($urandom_range(0, 3) == 3) ? 2 : 0);
  endtask

  initial begin
    clk = 1'b0; rstn = 1'b0; m_reqs = '0; slaves = '0; bus_util = 1'b0;
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_timeout();
    test_transfer();
    test_back_to_back();
    test_conflict();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, %0d/%0d", passes, checks);
    $fatal(1);
  end
endmodule
